// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_DIV_EN to build the divider (div/divu); without it those codes are no-ops.
module mdu_iterative (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  input  logic [3:0]  MDUCtrl,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] MUL_CYCLES = 4'd5;
`ifdef MDU_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] DIV_CYCLES = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  op;
  logic [31:0] opa, opb;
  logic        launch_mul, launch_div, launch, done;
  logic [63:0] ext_a, ext_b, prod;

  always_comb begin
    launch_mul = 1'b0;
    launch_div = 1'b0;
    if (state == IDLE && Start) begin
      launch_mul = (MDUCtrl == OP_MULT) || (MDUCtrl == OP_MULTU);
`ifdef MDU_DIV_EN
      launch_div = (MDUCtrl == OP_DIV) || (MDUCtrl == OP_DIVU);
`endif
    end
  end

  assign launch = launch_mul | launch_div;
  // cnt is 1 on the last busy cycle, so the result lands on the edge it would hit 0
  assign done   = (state == RUN) && (cnt == 4'd1);
  assign Busy   = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = RUN;
      RUN:  if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Sign- or zero-extend so a single 64-bit multiply covers both mult and multu
  assign ext_a = (op == OP_MULT) ? {{32{opa[31]}}, opa} : {32'd0, opa};
  assign ext_b = (op == OP_MULT) ? {{32{opb[31]}}, opb} : {32'd0, opb};
  assign prod  = ext_a * ext_b;

`ifdef MDU_DIV_EN
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, q_mag, r_mag, quo, rem;

  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend; 0x80000000 / -1 wraps back to 0x80000000.
  assign neg_a = (op == OP_DIV) && opa[31];
  assign neg_b = (op == OP_DIV) && opb[31];
  assign mag_a = neg_a ? (~opa + 32'd1) : opa;
  assign mag_b = neg_b ? (~opb + 32'd1) : opb;
  assign q_mag = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
  assign r_mag = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
  assign quo   = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
      op  <= 4'd0;
      opa <= 32'd0;
      opb <= 32'd0;
      HI  <= 32'd0;
      LO  <= 32'd0;
    end else begin
      if (launch) begin
        op  <= MDUCtrl;
        opa <= Operand1;
        opb <= Operand2;
`ifdef MDU_DIV_EN
        cnt <= launch_div ? DIV_CYCLES : MUL_CYCLES;
`else
        cnt <= MUL_CYCLES;
`endif
      end else if (state == RUN) begin
        cnt <= cnt - 4'd1;
      end

      if (state == IDLE && Start && MDUCtrl == OP_MTHI) HI <= Operand1;
      if (state == IDLE && Start && MDUCtrl == OP_MTLO) LO <= Operand1;

      if (done) begin
        if (op == OP_MULT || op == OP_MULTU) begin
          HI <= prod[63:32];
          LO <= prod[31:0];
        end
`ifdef MDU_DIV_EN
        else if (opb != 32'd0) begin
          HI <= rem;
          LO <= quo;
        end
`endif
      end
    end
  end

endmodule

// File: doc/mdu_iterative.md
MDU_ITERATIVE -- requirements
Module: mdu_iterative

Interface
REQ-001 Clock/reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 Operand1  in  32  rs value from the EX operand stage (multiplicand/dividend/mthi-mtlo source).
REQ-005 Operand2  in  32  rt value from the EX operand stage (multiplier/divisor).
REQ-006 MDUCtrl  in  4  op: 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo; all others no-op.
REQ-007 Start  in  1  one-cycle request qualifying MDUCtrl, Operand1 and Operand2.
REQ-008 Busy  out  1  high while an operation is in flight; the pipeline stalls on mfhi/mflo/MDU ops while high.
REQ-009 HI  out  32  architectural HI register.
REQ-010 LO  out  32  architectural LO register.

Function
REQ-011 States SHALL be IDLE and RUN; Busy SHALL be 1 exactly in RUN.
REQ-012 In IDLE, Start=1 with mult/multu SHALL capture operands, load counter=5 and enter RUN at the same edge.
REQ-013 In IDLE, Start=1 with div/divu SHALL capture operands, load counter=10 and enter RUN.
REQ-014 In RUN, the counter SHALL decrement each edge; on the edge where it reaches 0, HI/LO SHALL update and the state SHALL return to IDLE (Start at edge k -> Busy high for cycles k+1..k+N -> results visible after edge k+N).
REQ-015 mult SHALL produce the signed 64-bit product and multu the unsigned product: {HI,LO}=product.
REQ-016 div/divu SHALL set LO=quotient and HI=remainder; signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-017 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-018 A divide by zero (Operand2=0) SHALL still run 10 cycles and then leave HI/LO unchanged.
REQ-019 mthi/mtlo with Start=1 in IDLE SHALL write Operand1 to HI/LO at that edge, with no Busy and no state change.
REQ-020 Start=1 while in RUN SHALL be ignored, including mthi/mtlo; operands captured at launch SHALL not be disturbed.
REQ-021 Start=1 with a no-op code SHALL change nothing.
REQ-022 Operand inputs SHALL be sampled only at the launch edge; later changes SHALL have no effect on the result.
REQ-023 HI/LO SHALL change only on REQ-014, REQ-019 or reset.

Reset
REQ-024 When reset=1 at an edge: state=IDLE, counter=0, Busy=0, HI=0, LO=0, and captured operands cleared.
REQ-025 Reset in RUN SHALL abort the operation; no result SHALL be written after the reset is released.
REQ-026 Reset SHALL take priority over Start in the same cycle.

Configuration
REQ-027 Macro MDU_DIV_EN defined: div/divu are implemented per REQ-013/016/017/018.
REQ-028 MDU_DIV_EN undefined: codes 0011/0100 SHALL be treated as no-ops (no Busy, HI/LO unchanged), and no divider logic SHALL be synthesized.

Verification
REQ-029 mult 0xFFFFFFFE x 0x00000003 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 div 0xFFFFFFF9 (-7) / 2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1.
REQ-031 HI=LO=0x11111111, then div x/0 -> after 10 cycles HI=LO=0x11111111; also div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 mtlo 0xABCD0000 issued 2 cycles into a mult, and operands changed mid-run -> mtlo ignored; LO equals the product of the launch operands.
REQ-033 reset asserted in cycle 3 of a div -> Busy=0, HI=LO=0 next cycle, and they stay 0 for 12 further cycles.
REQ-034 Build without MDU_DIV_EN: divu 7/2 -> Busy stays 0 and HI/LO unchanged; mult still behaves per REQ-029.
